// File: rtl/permutation_engine.sv
// Ascon permutation p^a (a = 12/8/6) running UNROLL rounds per clock, from an accepted start_i to a done_o pulse.
// Latency is a/UNROLL edges after the accepting edge; start_i is ignored (never queued) while busy.

package ascon_pack;

  typedef logic [319:0] type_state;

  localparam logic [7:0] round_constant [0:11] = '{
    8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
    8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b
  };

  function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // Word order: x0 is the most significant 64 bits of the state.
  function automatic type_state ascon_round(input type_state s, input logic [3:0] idx);
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;
    x0 = s[319:256];
    x1 = s[255:192];
    x2 = s[191:128] ^ {56'd0, round_constant[idx]};
    x3 = s[127:64];
    x4 = s[63:0];
    // Bit-sliced 5-bit S-box.
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    x0 = x0 ^ ror64(x0, 19) ^ ror64(x0, 28);
    x1 = x1 ^ ror64(x1, 61) ^ ror64(x1, 39);
    x2 = x2 ^ ror64(x2, 1)  ^ ror64(x2, 6);
    x3 = x3 ^ ror64(x3, 10) ^ ror64(x3, 17);
    x4 = x4 ^ ror64(x4, 7)  ^ ror64(x4, 41);
    return {x0, x1, x2, x3, x4};
  endfunction

endpackage

module permutation_engine #(
  parameter int UNROLL = 1
) (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic         start_i,
  input  logic [1:0]   mode_i,
  input  logic [319:0] state_i,
  output logic [319:0] state_o,
  output logic [3:0]   round_o,
  output logic         busy_o,
  output logic         done_o
);

  if ((UNROLL != 1) && (UNROLL != 2)) begin : g_bad_unroll
    $error("permutation_engine: UNROLL must be 1 or 2");
  end

  localparam logic [3:0] STEP     = 4'(UNROLL);
  localparam logic [3:0] LAST_IDX = 4'd12 - STEP;

  typedef enum logic {IDLE, RUN} fsm_t;

  fsm_t         fsm, fsm_nxt;
  logic [3:0]   cnt;
  logic [3:0]   first_idx;
  logic         load, step, last;
  logic [319:0] state_q;
  logic [319:0] round_dat;
  logic         done_q;

  assign last = (cnt == LAST_IDX);

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) fsm <= IDLE;
    else         fsm <= fsm_nxt;
  end

  always_comb begin
    fsm_nxt = fsm;
    case (fsm)
      IDLE: if (start_i) fsm_nxt = RUN;
      RUN:  if (last)    fsm_nxt = IDLE;
      default:           fsm_nxt = IDLE;
    endcase
  end

  always_comb begin
    load    = (fsm == IDLE) && start_i;
    step    = (fsm == RUN);
    busy_o  = (fsm == RUN);
    round_o = (fsm == RUN) ? cnt : 4'd0;
  end

  // Shorter permutations run the tail of the 12-round constant schedule.
  always_comb begin
    case (mode_i)
      2'b01:   first_idx = 4'd4;
      2'b10:   first_idx = 4'd6;
      default: first_idx = 4'd0;
    endcase
  end

  always_comb begin
    round_dat = state_q;
    for (int r = 0; r < UNROLL; r++) begin
      round_dat = ascon_pack::ascon_round(round_dat, cnt + 4'(r));
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= '0;
      cnt     <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= step && last;
      if (load) begin
        state_q <= state_i;
        cnt     <= first_idx;
      end else if (step) begin
        state_q <= round_dat;
        cnt     <= last ? 4'd0 : cnt + STEP;
      end
    end
  end

  assign state_o = state_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_permutation_engine.sv
// Drives an UNROLL=1 and an UNROLL=2 engine side by side and checks every cycle against
// a table-driven Ascon reference built from the algorithm definition.

module tb_permutation_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         start_v [2];
  logic [1:0]   mode_v  [2];
  logic [319:0] sin_v   [2];
  logic [319:0] sout_v  [2];
  logic [3:0]   rnd_v   [2];
  logic         busy_v  [2];
  logic         done_v  [2];

  int n_cmp = 0;
  int n_err = 0;

  permutation_engine #(.UNROLL(1)) u1 (
    .clock_i(clk), .reset_i(rst), .start_i(start_v[0]), .mode_i(mode_v[0]),
    .state_i(sin_v[0]), .state_o(sout_v[0]), .round_o(rnd_v[0]),
    .busy_o(busy_v[0]), .done_o(done_v[0])
  );

  permutation_engine #(.UNROLL(2)) u2 (
    .clock_i(clk), .reset_i(rst), .start_i(start_v[1]), .mode_i(mode_v[1]),
    .state_i(sin_v[1]), .state_o(sout_v[1]), .round_o(rnd_v[1]),
    .busy_o(busy_v[1]), .done_o(done_v[1])
  );

  // Ascon S-box lookup table, input x0 as MSB.
  logic [4:0] sbox_t [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    logic [127:0] d;
    d = {x, x} >> n;
    return d[63:0];
  endfunction

  function automatic logic [319:0] model_round(input logic [319:0] s, input int idx);
    logic [63:0] w [5];
    logic [4:0]  col;
    logic [7:0]  rc;
    for (int i = 0; i < 5; i++) w[i] = s[319 - 64*i -: 64];
    rc   = 8'(((15 - idx) << 4) | idx);
    w[2] = w[2] ^ {56'd0, rc};
    for (int b = 0; b < 64; b++) begin
      col = sbox_t[{w[0][b], w[1][b], w[2][b], w[3][b], w[4][b]}];
      w[0][b] = col[4];
      w[1][b] = col[3];
      w[2][b] = col[2];
      w[3][b] = col[1];
      w[4][b] = col[0];
    end
    w[0] = w[0] ^ rotr(w[0], 19) ^ rotr(w[0], 28);
    w[1] = w[1] ^ rotr(w[1], 61) ^ rotr(w[1], 39);
    w[2] = w[2] ^ rotr(w[2], 1)  ^ rotr(w[2], 6);
    w[3] = w[3] ^ rotr(w[3], 10) ^ rotr(w[3], 17);
    w[4] = w[4] ^ rotr(w[4], 7)  ^ rotr(w[4], 41);
    return {w[0], w[1], w[2], w[3], w[4]};
  endfunction

  function automatic logic [319:0] model_rounds(input logic [319:0] s, input int first, input int count);
    logic [319:0] t;
    t = s;
    for (int i = 0; i < count; i++) t = model_round(t, first + i);
    return t;
  endfunction

  function automatic logic [319:0] rand320();
    logic [319:0] r;
    for (int i = 0; i < 10; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One operation per engine (two when b2b: second start held through the done cycle).
  task automatic run_pair(input logic [1:0] md, input logic [319:0] s0,
                          input logic [319:0] s1, input bit b2b);
    int a, first, n [2], e [2], ph [2];
    bit fin [2];
    logic [319:0] mst [2];
    a     = (md == 2'b01) ? 8 : (md == 2'b10) ? 6 : 12;
    first = 12 - a;
    for (int k = 0; k < 2; k++) begin
      n[k] = a / (k + 1); e[k] = 0; ph[k] = 0; fin[k] = 1'b0; mst[k] = s0;
      start_v[k] = 1'b1; mode_v[k] = md; sin_v[k] = s0;
    end
    @(posedge clk); #1;
    for (int cyc = 0; cyc < 64 && !(fin[0] && fin[1]); cyc++) begin
      for (int k = 0; k < 2; k++) begin
        if (!fin[k]) begin
          if (e[k] == 0) begin
            if (!b2b) start_v[k] = 1'b0;
            mode_v[k] = 2'($urandom);
            sin_v[k]  = rand320();
          end
          if (e[k] < n[k]) begin
            chk($sformatf("u%0d m%0d e%0d busy", k, md, e[k]), 320'(busy_v[k]), 320'd1);
            chk($sformatf("u%0d m%0d e%0d done", k, md, e[k]), 320'(done_v[k]), 320'd0);
            chk($sformatf("u%0d m%0d e%0d round", k, md, e[k]), 320'(rnd_v[k]),
                320'(first + e[k] * (k + 1)));
            chk($sformatf("u%0d m%0d e%0d state", k, md, e[k]), sout_v[k], mst[k]);
          end else begin
            chk($sformatf("u%0d m%0d end busy", k, md), 320'(busy_v[k]), 320'd0);
            chk($sformatf("u%0d m%0d end done", k, md), 320'(done_v[k]), 320'd1);
            chk($sformatf("u%0d m%0d end round", k, md), 320'(rnd_v[k]), 320'd0);
            chk($sformatf("u%0d m%0d end state", k, md), sout_v[k], mst[k]);
            if (b2b && ph[k] == 0) begin
              ph[k] = 1; e[k] = -1; mst[k] = s1;
              sin_v[k] = s1; mode_v[k] = md;
            end else begin
              start_v[k] = 1'b0;
              fin[k] = 1'b1;
            end
          end
        end
      end
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
        if (!fin[k]) begin
          e[k]++;
          if (e[k] >= 1 && e[k] <= n[k])
            mst[k] = model_rounds(mst[k], first + (e[k] - 1) * (k + 1), k + 1);
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("u%0d m%0d timeout", k, md), 320'(fin[k]), 320'd1);
      chk($sformatf("u%0d m%0d idle done", k, md), 320'(done_v[k]), 320'd0);
      chk($sformatf("u%0d m%0d idle busy", k, md), 320'(busy_v[k]), 320'd0);
      chk($sformatf("u%0d m%0d hold state", k, md), sout_v[k], mst[k]);
    end
  endtask

  initial begin
    logic [319:0] kat;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      start_v[k] = 1'b0; mode_v[k] = 2'b00; sin_v[k] = '0;
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("u%0d reset state", k), sout_v[k], 320'd0);
      chk($sformatf("u%0d reset busy", k), 320'(busy_v[k]), 320'd0);
      chk($sformatf("u%0d reset done", k), 320'(done_v[k]), 320'd0);
      chk($sformatf("u%0d reset round", k), 320'(rnd_v[k]), 320'd0);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Abort p^12 mid-run: async reset clears everything before the next edge.
    for (int k = 0; k < 2; k++) begin
      start_v[k] = 1'b1; mode_v[k] = 2'b00; sin_v[k] = rand320();
    end
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) start_v[k] = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("u%0d abort state", k), sout_v[k], 320'd0);
      chk($sformatf("u%0d abort busy", k), 320'(busy_v[k]), 320'd0);
      chk($sformatf("u%0d abort done", k), 320'(done_v[k]), 320'd0);
      chk($sformatf("u%0d abort round", k), 320'(rnd_v[k]), 320'd0);
    end
    @(posedge clk); #1 rst = 1'b0;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("u%0d post-abort done c%0d", k, c), 320'(done_v[k]), 320'd0);
        chk($sformatf("u%0d post-abort busy c%0d", k, c), 320'(busy_v[k]), 320'd0);
      end
    end

    // IV || K || N for Ascon-128 with a counting key and nonce.
    kat = {64'h80400c0600000000,
           128'h000102030405060708090a0b0c0d0e0f,
           128'h000102030405060708090a0b0c0d0e0f};
    run_pair(2'b00, kat, '0, 1'b0);
    run_pair(2'b10, rand320(), '0, 1'b0);
    run_pair(2'b01, rand320(), '0, 1'b0);
    run_pair(2'b00, rand320(), rand320(), 1'b1);
    run_pair(2'b10, rand320(), rand320(), 1'b1);
    run_pair(2'b01, rand320(), rand320(), 1'b1);
    run_pair(2'b11, '0, '0, 1'b0);
    for (int i = 0; i < 4; i++)
      run_pair(2'($urandom), rand320(), rand320(), 1'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
